// File: rtl/fmap_replay_buffer.sv
// fmap_replay_buffer
//   Captures one WIDTH x WIDTH feature map of CH-channel pixel vectors from
//   an upstream layer, written in raster order. On a start pulse it replays
//   the map as a valid-qualified stream for the next layer.
//   Optional build macro: FMAP_GAP_EN inserts GAP idle cycles after each
//   replayed row.
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   i_data     upstream pixel vector, qualified by valid_in
//   valid_in   i_data valid this cycle
//   start      one-cycle pulse that begins replay; only honoured while full
//   o_data     replayed pixel vector (registered; holds when valid_out=0)
//   valid_out  o_data valid this cycle
//   full       map captured, waiting for start
//   busy       replay in progress
//   done       one-cycle pulse on the cycle after the replay ends
//   overflow   sticky: a vector arrived while full/busy and was dropped
module fmap_replay_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int CH         = 32,
   parameter int WIDTH      = 7,
   parameter int GAP        = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_WIDTH*CH-1:0] i_data,
   input  logic                     valid_in,
   input  logic                     start,
   output logic [DATA_WIDTH*CH-1:0] o_data,
   output logic                     valid_out,
   output logic                     full,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow
);
   localparam int VW  = DATA_WIDTH * CH;
   localparam int DIM = WIDTH * WIDTH;
   localparam int AW  = (DIM > 1) ? $clog2(DIM) : 1;

   typedef enum logic [1:0] {S_FILL, S_FULL, S_DRAIN} state_t;
   state_t state, state_nxt;

   logic [VW-1:0] mem [DIM];
   logic [VW-1:0] rd_q;
   logic [AW-1:0] wr_addr, rd_addr;
   logic          wr_en, wr_last, issue, rd_last, in_gap, final_slot;
   logic          rd_vld;     // rd_q holds a vector issued last cycle
   logic          tail;       // final slot issued; flushing the read pipeline
   logic [1:0]    fin_pipe;   // final slot delayed to line up with done

   assign wr_en   = rst && (state == S_FILL) && valid_in;
   assign wr_last = (wr_addr == AW'(DIM-1));
   assign rd_last = (rd_addr == AW'(DIM-1));
   assign issue   = (state == S_DRAIN) && !tail && !in_gap;
   assign full    = (state == S_FULL);
   assign busy    = (state == S_DRAIN);

`ifdef FMAP_GAP_EN
   localparam int GW = (GAP > 0) ? $clog2(GAP+1) : 1;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   logic [GW-1:0] gap_cnt;
   logic [CW-1:0] col;

   assign in_gap = (gap_cnt != '0);
   // rd_addr wraps to 0 only after the last vector, so a gap seen with
   // rd_addr==0 belongs to the final row; its last cycle ends the replay.
   assign final_slot = (GAP == 0) ? (issue && rd_last)
                                  : (in_gap && gap_cnt == GW'(1) && rd_addr == '0);

   always_ff @(posedge clk) begin
      if (!rst || state != S_DRAIN) begin
         gap_cnt <= '0;
         col     <= '0;
      end else if (issue) begin
         if (col == CW'(WIDTH-1)) begin
            col     <= '0;
            gap_cnt <= GW'(GAP);
         end else begin
            col <= col + 1'b1;
         end
      end else if (in_gap) begin
         gap_cnt <= gap_cnt - 1'b1;
      end
   end
`else
   assign in_gap     = 1'b0;
   assign final_slot = issue && rd_last;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_FILL:  if (wr_en && wr_last) state_nxt = S_FULL;
         S_FULL:  if (start)            state_nxt = S_DRAIN;
         S_DRAIN: if (fin_pipe[1])      state_nxt = S_FILL;
         default:                       state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_FILL;
         wr_addr   <= '0;
         rd_addr   <= '0;
         tail      <= 1'b0;
         rd_vld    <= 1'b0;
         fin_pipe  <= '0;
         o_data    <= '0;
         valid_out <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wr_en) wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
         if (issue) rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
         if (fin_pipe[1])     tail <= 1'b0;
         else if (final_slot) tail <= 1'b1;
         rd_vld    <= issue;
         fin_pipe  <= {fin_pipe[0], final_slot};
         valid_out <= rd_vld;
         if (rd_vld) o_data <= rd_q;
         done      <= fin_pipe[1];
         if (valid_in && state != S_FILL) overflow <= 1'b1;
      end
   end

   // Storage: synchronous write, registered read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= i_data;
      rd_q <= mem[rd_addr];
   end
endmodule

// File: tb/tb_fmap_replay_buffer.sv
module tb_fmap_replay_buffer;
   localparam int DW = 8, CHN = 4, WD = 7, GP = 2;
   localparam int VW = DW * CHN, DIM = WD * WD;
`ifdef FMAP_GAP_EN
   localparam int GAPS = GP;
`else
   localparam int GAPS = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [VW-1:0] i_data = '0;
   logic          valid_in = 1'b0;
   logic          start = 1'b0;
   logic [VW-1:0] o_data;
   logic          valid_out, full, busy, done, overflow;

   int n_run = 0, n_fail = 0;

   fmap_replay_buffer #(.DATA_WIDTH(DW), .CH(CHN), .WIDTH(WD), .GAP(GP)) dut (
      .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .start(start),
      .o_data(o_data), .valid_out(valid_out), .full(full), .busy(busy),
      .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic fill(input int off, input bit holes, input int start_k);
      for (int k = 0; k < DIM; k++) begin
         valid_in = 1'b1;
         i_data   = VW'(k + off);
         start    = (k == start_k);
         tick();
         start = 1'b0;
         if (k == start_k) chk("start_ignored_busy", 32'(busy), 0);
         if (k == DIM-2)   chk("full_before_last", 32'(full), 0);
         if (holes) begin
            valid_in = 1'b0;
            tick();
         end
      end
      valid_in = 1'b0;
      chk("full_after_fill", 32'(full), 1);
      chk("busy_after_fill", 32'(busy), 0);
   endtask

   task automatic drain(input int off);
      int            idx;
      logic [VW-1:0] last;
      bit            ev;
      idx   = 0;
      last  = o_data;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("drain_busy", 32'(busy), 1);
      chk("drain_full", 32'(full), 0);
      tick();
      chk("drain_latency", 32'(valid_out), 0);
      for (int j = 0; j < DIM + WD*GAPS; j++) begin
         tick();
         ev = ((j % (WD + GAPS)) < WD);
         chk("vo_pattern", 32'(valid_out), 32'(ev));
         chk("no_early_done", 32'(done), 0);
         if (ev) begin
            chk("o_data", o_data, VW'(idx + off));
            last = VW'(idx + off);
            idx++;
         end else begin
            chk("o_data_hold", o_data, last);
         end
      end
      tick();
      chk("done_pulse", 32'(done), 1);
      chk("done_valid_out", 32'(valid_out), 0);
      chk("done_busy", 32'(busy), 0);
      chk("done_full", 32'(full), 0);
      tick();
      chk("done_single", 32'(done), 0);
   endtask

   initial begin
      int cnt;
      // 1: reset held two cycles with valid_in asserted
      rst = 1'b0; valid_in = 1'b1; i_data = VW'(32'hDEADBEEF);
      tick(); tick();
      chk("rst_o_data", o_data, 0);
      chk("rst_valid_out", 32'(valid_out), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_overflow", 32'(overflow), 0);
      valid_in = 1'b0;
      rst = 1'b1;
      tick();

      // 2: plain fill and replay
      fill(0, 1'b0, -1);
      drain(0);
      chk("t2_overflow", 32'(overflow), 0);

      // 3: holes every other cycle; start coincides with final write
      fill(200, 1'b1, DIM-1);
      drain(200);

      // 4: start during FILL ignored; extra vector while FULL dropped
      fill(0, 1'b0, 10);
      valid_in = 1'b1; i_data = VW'(99);
      tick();
      valid_in = 1'b0;
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_still_full", 32'(full), 1);
      drain(0);
      chk("ovf_sticky", 32'(overflow), 1);

      // 5: reset at the 20th valid_out
      fill(300, 1'b0, -1);
      start = 1'b1; tick(); start = 1'b0;
      cnt = 0;
      for (int j = 0; j < 100 && cnt < 20; j++) begin
         tick();
         if (valid_out) cnt++;
      end
      chk("abort_reached_20", 32'(cnt), 20);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("abort_valid_out", 32'(valid_out), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_full", 32'(full), 0);
      chk("abort_overflow", 32'(overflow), 0);
      fill(400, 1'b0, -1);
      drain(400);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
